uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 160 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses "(x,y)" ASCII commands from a UART byte stream into place/fire commands.
// Define UART_CMD_ECHO_EN to echo every received byte on tx_data/tx_valid one cycle later.
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [2:0] game_state,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] cmd_x,
  output logic [3:0] cmd_y,
  output logic       cmd_fire,
  output logic       cmd_player,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] tx_data,
  output logic       tx_valid
);
  typedef enum logic [2:0] {IDLE, GOT_OPEN, GOT_X, GOT_COMMA, GOT_Y, GOT_CLOSE, DISCARD, PEND} state_e;
  state_e state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d, cmd_x_q, cmd_x_d, cmd_y_q, cmd_y_d;
  logic fire_q, fire_d, player_q, player_d, err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [TO_W-1:0] to_q, to_d;
  logic is_digit, is_term, is_space, gs_ok, timing, timeout, bad, done;
  logic [3:0] digit;
  assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
  assign is_term  = rx_data == 8'h0D || rx_data == 8'h0A;
  assign is_space = rx_data == 8'h20;
  assign digit    = rx_data[3:0];
  assign gs_ok    = game_state >= 3'd1 && game_state <= 3'd4;
  assign timing   = state_q inside {GOT_OPEN, GOT_X, GOT_COMMA, GOT_Y, GOT_CLOSE};
  assign timeout  = timing && !rx_valid && to_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign to_d     = (timing && !rx_valid) ? to_q + 1'b1 : '0;
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cmd_x_d  = cmd_x_q;
    cmd_y_d  = cmd_y_q;
    fire_d   = fire_q;
    player_d = player_q;
    err_d    = 1'b0;
    code_d   = code_q;
    bad      = 1'b0;
    done     = 1'b0;
    if (state_q == PEND) begin
      if (rx_valid) begin
        err_d  = 1'b1;
        code_d = 2'd3;
      end
      if (cmd_ready) state_d = IDLE;
    end else if (timeout) begin
      err_d   = 1'b1;
      code_d  = 2'd1;
      state_d = IDLE;
    end else if (rx_valid && !is_space) begin
      case (state_q)
        IDLE:
          if (rx_data == 8'h28) state_d = GOT_OPEN;
          else if (is_digit) begin
            x_d     = digit;
            state_d = GOT_X;
          end else if (!is_term) bad = 1'b1;
        GOT_OPEN:
          if (is_digit) begin
            x_d     = digit;
            state_d = GOT_X;
          end else bad = 1'b1;
        GOT_X:
          if (rx_data == 8'h2C) state_d = GOT_COMMA;
          else bad = 1'b1;
        GOT_COMMA:
          if (is_digit) begin
            y_d     = digit;
            state_d = GOT_Y;
          end else bad = 1'b1;
        GOT_Y:
          if (rx_data == 8'h29) state_d = GOT_CLOSE;
          else if (is_term) done = 1'b1;
          else bad = 1'b1;
        GOT_CLOSE:
          if (is_term) done = 1'b1;
          else bad = 1'b1;
        DISCARD:
          if (is_term) state_d = IDLE;
        default: ;
      endcase
      // a terminator that is itself the offending byte already ends the line
      if (bad) begin
        err_d   = 1'b1;
        code_d  = 2'd0;
        state_d = is_term ? IDLE : DISCARD;
      end
      if (done && gs_ok) begin
        cmd_x_d  = x_q;
        cmd_y_d  = y_q;
        fire_d   = game_state >= 3'd3;
        player_d = game_state == 3'd2 || game_state == 3'd4;
        state_d  = PEND;
      end else if (done) begin
        err_d   = 1'b1;
        code_d  = 2'd2;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      cmd_x_q  <= '0;
      cmd_y_q  <= '0;
      fire_q   <= 1'b0;
      player_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cmd_x_q  <= cmd_x_d;
      cmd_y_q  <= cmd_y_d;
      fire_q   <= fire_d;
      player_q <= player_d;
      err_q    <= err_d;
      code_q   <= code_d;
      to_q     <= to_d;
    end
  assign cmd_valid  = state_q == PEND;
  assign cmd_x      = cmd_x_q;
  assign cmd_y      = cmd_y_q;
  assign cmd_fire   = fire_q;
  assign cmd_player = player_q;
  assign err        = err_q;
  assign err_code   = code_q;
`ifdef UART_CMD_ECHO_EN
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= rx_valid;
      if (rx_valid) tx_data_q <= rx_data;
    end
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
`else
  assign tx_data  = 8'h00;
  assign tx_valid = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and random byte streams checked each cycle against a line-buffer model.
module tb_uart_cmd_parser;
  localparam int T = 16;
`ifdef UART_CMD_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, cmd_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic [2:0] game_state = '0;
  logic cmd_valid, cmd_fire, cmd_player, err, tx_valid;
  logic [3:0] cmd_x, cmd_y;
  logic [1:0] err_code;
  logic [7:0] tx_data;
  int checks = 0, failures = 0, nvalid = 0;
  logic rdy = 1'b0, rnd_rdy = 1'b0;
  logic [2:0] gs = '0;
  logic [7:0] ln[$];
  bit disc, pend;
  int idle;
  logic e_valid, e_fire, e_player, e_err, e_txv;
  logic [3:0] e_x, e_y;
  logic [1:0] e_code;
  logic [7:0] e_txd;
  logic [7:0] junk [16] = '{"0", "5", "9", "(", ")", ",", ",", " ", 8'h0D, 8'h0A, "A", "Z", ";", "x", "3", "7"};

  uart_cmd_parser #(.TIMEOUT_CYCLES(T), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .game_state(game_state),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_fire(cmd_fire),
    .cmd_player(cmd_player), .err(err), .err_code(err_code), .tx_data(tx_data), .tx_valid(tx_valid));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".cmd_valid"}, 8'(cmd_valid), 8'(e_valid));
    chk({tag, ".cmd_x"}, 8'(cmd_x), 8'(e_x));
    chk({tag, ".cmd_y"}, 8'(cmd_y), 8'(e_y));
    chk({tag, ".cmd_fire"}, 8'(cmd_fire), 8'(e_fire));
    chk({tag, ".cmd_player"}, 8'(cmd_player), 8'(e_player));
    chk({tag, ".err"}, 8'(err), 8'(e_err));
    chk({tag, ".err_code"}, 8'(err_code), 8'(e_code));
    chk({tag, ".tx_valid"}, 8'(tx_valid), 8'(e_txv));
    chk({tag, ".tx_data"}, tx_data, e_txd);
  endtask

  function automatic bit is_dig(logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic int lead();
    return (ln.size() > 0 && ln[0] == "(") ? 1 : 0;
  endfunction

  // line buffer must be a prefix of [(] d , d [)]
  function automatic bit prefix_ok();
    int off = lead();
    if (ln.size() - off > 4) return 1'b0;
    for (int i = off; i < ln.size(); i++) begin
      int k = i - off;
      if (k == 0 && !is_dig(ln[i])) return 1'b0;
      if (k == 1 && ln[i] != ",") return 1'b0;
      if (k == 2 && !is_dig(ln[i])) return 1'b0;
      if (k == 3 && ln[i] != ")") return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic raise(logic [1:0] code);
    e_err  = 1'b1;
    e_code = code;
  endtask

  task automatic model(logic v, logic [7:0] d);
    bit term = d == CR || d == LF;
    int off;
    e_err = 1'b0;
    e_txv = ECHO && v;
    if (ECHO && v) e_txd = d;
    if (pend) begin
      if (v) raise(2'd3);
      if (rdy) begin
        pend    = 1'b0;
        e_valid = 1'b0;
      end
    end else if (v) begin
      idle = 0;
      if (d == " ") ;
      else if (disc) disc = !term;
      else if (term) begin
        off = lead();
        if (ln.size() == 0) ;
        else if (ln.size() - off >= 3) begin
          if (gs >= 1 && gs <= 4) begin
            e_x      = 4'(ln[off] - "0");
            e_y      = 4'(ln[off + 2] - "0");
            e_fire   = gs >= 3;
            e_player = gs == 2 || gs == 4;
            e_valid  = 1'b1;
            pend     = 1'b1;
          end else raise(2'd2);
        end else raise(2'd0);
        ln.delete();
      end else begin
        ln.push_back(d);
        if (!prefix_ok()) begin
          raise(2'd0);
          ln.delete();
          disc = 1'b1;
        end
      end
    end else if (ln.size() != 0) begin
      idle++;
      if (idle == T) begin
        raise(2'd1);
        ln.delete();
        idle = 0;
      end
    end
  endtask

  task automatic cyc(logic v, logic [7:0] d);
    @(negedge clk);
    if (rnd_rdy) rdy = 1'($urandom % 2);
    rx_valid   = v;
    rx_data    = d;
    cmd_ready  = rdy;
    game_state = gs;
    model(v, d);
    @(posedge clk);
    #1;
    chk_all("cyc");
    if (cmd_valid) nvalid++;
  endtask

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i]);
  endtask

  task automatic idle_n(int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    ln.delete();
    {disc, pend, idle} = '0;
    {e_valid, e_fire, e_player, e_err, e_txv, e_x, e_y, e_code, e_txd} = '0;
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_cmd();
    logic [7:0] q[$];
    if ($urandom % 2) q.push_back("(");
    q.push_back(8'h30 + 8'($urandom % 10));
    q.push_back(",");
    q.push_back(8'h30 + 8'($urandom % 10));
    if ($urandom % 2) q.push_back(")");
    q.push_back(($urandom % 2) ? CR : LF);
    foreach (q[i]) begin
      if ($urandom % 4 == 0) cyc(1'b1, " ");
      cyc(1'b1, q[i]);
      idle_n($urandom % 3);
    end
  endtask

  initial begin
    do_reset();
    gs = 3'd3; rdy = 1'b1; nvalid = 0;
    send("(3,7)"); cyc(1'b1, CR); idle_n(3);
    chk("one_pulse", 8'(nvalid), 8'd1);
    gs = 3'd2; rdy = 1'b0; nvalid = 0;
    send("4 , 9"); cyc(1'b1, LF); idle_n(2);
    cyc(1'b1, "A"); idle_n(2);
    rdy = 1'b1; idle_n(3);
    chk("held_5", 8'(nvalid >= 5), 8'd1);
    gs = 3'd3; nvalid = 0;
    send("(3;7)"); cyc(1'b1, CR); idle_n(2);
    chk("no_cmd_syntax", 8'(nvalid), 8'd0);
    send("1,2"); cyc(1'b1, CR); idle_n(2);
    send("5,"); idle_n(20);
    cyc(1'b1, CR); idle_n(2);
    gs = 3'd5; nvalid = 0;
    send("2,2"); cyc(1'b1, CR); idle_n(2);
    chk("no_cmd_gs5", 8'(nvalid), 8'd0);
    gs = 3'd4;
    send("(6,");
    do_reset();
    nvalid = 0;
    cyc(1'b1, CR); idle_n(2);
    chk("no_cmd_after_rst", 8'(nvalid), 8'd0);
    send("7,8)"); cyc(1'b1, LF); idle_n(2);
    cyc(1'b1, "Z"); idle_n(2);
    rnd_rdy = 1'b1;
    for (int it = 0; it < 400; it++) begin
      case ($urandom % 6)
        0, 1: send_cmd();
        2: repeat ($urandom_range(1, 6)) cyc(1'b1, junk[$urandom % 16]);
        3: idle_n($urandom_range(1, 20));
        4: gs = 3'($urandom % 6);
        default: if ($urandom % 20 == 0) do_reset(); else idle_n(1);
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
